// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction
// counters, looked up combinationally on the fetch PC and trained by EX.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 global advance enable (0 freezes all state)
//   pc                  fetch PC -> pred_taken / pred_next (combinational)
//   upd_*               resolved branch/jump from EX -> mispredict / correct_pc
//   flush / busy        whole-table invalidate request / walk in progress
//   br_cnt / miss_cnt   resolved-branch and misprediction statistics
module branch_predictor #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned MODE    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_next,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_pred_taken,
    input  logic [WIDTH-1:0] upd_pred_target,
    output logic             mispredict,
    output logic [WIDTH-1:0] correct_pc,
    input  logic             flush,
    output logic             busy,
    output logic [31:0]      br_cnt,
    output logic [31:0]      miss_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [WIDTH-1:0]   tgt_q [ENTRIES];
    logic [WIDTH-1:0]   tgt_d [ENTRIES];
    logic [31:0]        br_q, br_d;
    logic [31:0]        miss_q, miss_d;

    logic [IDX_W-1:0]   pc_idx, up_idx;
    logic [TAG_W-1:0]   pc_tag, up_tag;
    logic               pc_hit, up_hit, accept;

    // Lookup on the fetch PC; reads the pre-update table contents.
    assign pc_idx     = pc[IDX_W+1:2];
    assign pc_tag     = pc[IDX_W+TAG_W+1:IDX_W+2];
    assign pc_hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign busy       = (state_q == CLEAR);
    assign pred_taken = !busy && pc_hit && (MODE == 1) && cnt_q[pc_idx][CNT_W-1];
    assign pred_next  = pred_taken ? tgt_q[pc_idx] : pc + WIDTH'(4);

    // Resolution from EX.
    assign up_idx     = upd_pc[IDX_W+1:2];
    assign up_tag     = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign mispredict = upd_valid && !busy &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + WIDTH'(4);
    assign accept     = run && upd_valid && !busy;

    assign br_cnt   = br_q;
    assign miss_cnt = miss_q;

    // Next state: flush walk, table training, statistics.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        br_d    = br_q;
        miss_d  = miss_q;

        if (run) begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_d = CLEAR;
                        ptr_d   = '0;
                    end
                end
                CLEAR: begin
                    valid_d[ptr_q] = 1'b0;
                    if (ptr_q == IDX_LAST) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // accept implies IDLE, so training never collides with the walk
        if (accept) begin
            br_d = br_q + 32'd1;
            if (mispredict) begin
                miss_d = miss_q + 32'd1;
            end
            if (upd_taken) begin
                if (up_hit) begin
                    tgt_d[up_idx] = upd_target;
                    if (cnt_q[up_idx] != CNT_MAX) begin
                        cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
                    end
                end else begin
                    valid_d[up_idx] = 1'b1;
                    tag_d[up_idx]   = up_tag;
                    tgt_d[up_idx]   = upd_target;
                    cnt_d[up_idx]   = CNT_WEAK;
                end
            end else if (up_hit && (cnt_q[up_idx] != '0)) begin
                cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
            end
        end
    end

    // Control state, valid bits, counters and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= '0;
            br_q    <= '0;
            miss_q  <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            br_q    <= br_d;
            miss_q  <= miss_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag and target storage; only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule
